axi_sram_slave: RTL and testbench

AXI3-style single-ID slave (responder) that terminates the CPU's AXI master port and backs it with an on-chip word-addressed RAM. It is used in simulation and FPGA bring-up so the CPU, caches and AXI interface can run without the external SoC interconnect. Read and write channels have independent state machines that share one memory array. The memory has one read port and one byte-enable write port.

---
 rtl/axi_sram_if.sv | 75 +++++++
 rtl/axi_sram_slave.sv | 191 +++++++++++++++++++
 tb/tb_axi_sram_slave.sv | 361 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_sram_if.sv
// AXI3 channel bundle between the CPU master port and the on-chip SRAM responder.
// Clock and reset stay outside the bundle as plain ports.
interface axi_sram_if;
    // Read address channel
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;

    // Read data channel
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    // Write address channel
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [1:0]  awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;

    // Write data channel
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    // Write response channel
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );
endinterface

// File: rtl/axi_sram_slave.sv
// Single-ID AXI3 responder backed by a word-addressed RAM (one read port, one byte-enable write port).
// Read and write channels run independent FSMs; every burst is treated as INCR.
module axi_sram_slave #(
    parameter int ADDR_WIDTH = 14,
    parameter     INIT_FILE  = ""
) (
    input logic        aclk,
    input logic        aresetn,
    axi_sram_if.slave  bus
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    logic [31:0] mem [DEPTH];

    // Sizes above one word behave as full-word beats.
    function automatic logic [1:0] clamp_size(input logic [2:0] size);
        return (size > 3'd2) ? 2'd2 : size[1:0];
    endfunction

    function automatic logic [31:0] beat_step(input logic [1:0] size);
        return 32'd1 << size;
    endfunction

    // ---------------- Read channel ----------------
    r_state_t    r_state;
    logic [31:0] r_addr;
    logic [7:0]  r_len;
    logic [7:0]  r_cnt;
    logic [1:0]  r_size;
    logic        arready_q;
    logic        rvalid_q;
    logic        rlast_q;
    logic [3:0]  rid_q;
    logic [31:0] rdata_q;

    logic [ADDR_WIDTH-1:0] r_idx;
    assign r_idx = r_addr[ADDR_WIDTH+1:2];

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; that is also what gives the read-before-write ordering.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state   <= R_IDLE;
            r_addr    <= '0;
            r_len     <= '0;
            r_cnt     <= '0;
            r_size    <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rid_q     <= '0;
            rdata_q   <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    arready_q <= 1'b1;
                    if (bus.arvalid && arready_q) begin
                        rid_q     <= bus.arid;
                        r_addr    <= bus.araddr;
                        r_len     <= bus.arlen;
                        r_size    <= clamp_size(bus.arsize);
                        r_cnt     <= '0;
                        arready_q <= 1'b0;
                        r_state   <= R_FETCH;
                    end
                end
                R_FETCH: begin
                    rdata_q  <= mem[r_idx];
                    rvalid_q <= 1'b1;
                    rlast_q  <= (r_cnt == r_len);
                    r_state  <= R_DATA;
                end
                R_DATA: begin
                    // rdata/rid/rlast hold until the master takes the beat.
                    if (bus.rready) begin
                        rvalid_q <= 1'b0;
                        rlast_q  <= 1'b0;
                        if (rlast_q) begin
                            arready_q <= 1'b1;
                            r_state   <= R_IDLE;
                        end else begin
                            r_addr  <= r_addr + beat_step(r_size);
                            r_cnt   <= r_cnt + 8'd1;
                            r_state <= R_FETCH;
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // ---------------- Write channel ----------------
    w_state_t    w_state;
    logic [31:0] w_addr;
    logic [3:0]  w_len;
    logic [3:0]  w_cnt;
    logic [1:0]  w_size;
    logic        awready_q;
    logic        wready_q;
    logic        bvalid_q;
    logic [3:0]  bid_q;

    logic [ADDR_WIDTH-1:0] w_idx;
    logic                  w_fire;
    assign w_idx  = w_addr[ADDR_WIDTH+1:2];
    assign w_fire = wready_q && bus.wvalid;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state   <= W_IDLE;
            w_addr    <= '0;
            w_len     <= '0;
            w_cnt     <= '0;
            w_size    <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    awready_q <= 1'b1;
                    if (bus.awvalid && awready_q) begin
                        bid_q     <= bus.awid;
                        w_addr    <= bus.awaddr;
                        w_len     <= bus.awlen;
                        w_size    <= clamp_size(bus.awsize);
                        w_cnt     <= '0;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b1;
                        w_state   <= W_DATA;
                    end
                end
                W_DATA: begin
                    // Beat count alone ends the burst; wlast is not consulted.
                    if (w_fire) begin
                        if (w_cnt == w_len) begin
                            wready_q <= 1'b0;
                            bvalid_q <= 1'b1;
                            w_state  <= W_RESP;
                        end else begin
                            w_addr <= w_addr + beat_step(w_size);
                            w_cnt  <= w_cnt + 4'd1;
                        end
                    end
                end
                W_RESP: begin
                    if (bus.bready) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        w_state   <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // NOTE: the memory array has no reset; contents must survive aresetn and
    // a reset branch would also prevent RAM inference.
    always_ff @(posedge aclk) begin
        if (w_fire) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.wstrb[b]) mem[w_idx][8*b +: 8] <= bus.wdata[8*b +: 8];
            end
        end
    end

    assign bus.arready = arready_q;
    assign bus.rid     = rid_q;
    assign bus.rdata   = rdata_q;
    assign bus.rresp   = 2'b00;
    assign bus.rlast   = rlast_q;
    assign bus.rvalid  = rvalid_q;
    assign bus.awready = awready_q;
    assign bus.wready  = wready_q;
    assign bus.bid     = bid_q;
    assign bus.bresp   = 2'b00;
    assign bus.bvalid  = bvalid_q;

    logic unused_ok;
    assign unused_ok = ^{bus.arburst, bus.arlock, bus.arcache, bus.arprot,
                         bus.awburst, bus.awlock, bus.awcache, bus.awprot,
                         bus.wid, bus.wlast};

endmodule

// File: tb/tb_axi_sram_slave.sv
// Randomized scoreboard bench for axi_sram_slave: drivers push expected R beats / B ids,
// independent monitors pop and compare whenever the DUT presents a response.
module tb_axi_sram_slave;

    localparam int AW    = 8;
    localparam int DEPTH = 1 << AW;

    logic aclk    = 1'b0;
    logic aresetn = 1'b0;

    axi_sram_if bus ();

    axi_sram_slave #(.ADDR_WIDTH(AW)) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus)
    );

    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic        last;
    } r_beat_t;

    r_beat_t     r_exp [$];
    logic [3:0]  b_exp [$];
    logic [31:0] ref_mem [DEPTH];
    logic [31:0] wd_buf [16];
    logic [3:0]  ws_buf [16];

    int errors = 0;
    int checks = 0;
    int rready_mode = 0;  // 0: always ready, 1: random, 2: never
    int bready_mode = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at t=%0t", name, got, exp, $time);
        end
    endtask

    // Reference: word touched by a byte address, memory aliased modulo depth.
    function automatic int word_of(input logic [31:0] a);
        return int'((a >> 2) % 32'(DEPTH));
    endfunction

    function automatic logic [31:0] step_of(input logic [2:0] sz);
        return (sz > 3'd2) ? 32'd4 : (32'd1 << sz);
    endfunction

    // ---------------- Ready generators ----------------
    initial begin
        bus.rready = 1'b0;
        forever begin
            @(posedge aclk); #1;
            case (rready_mode)
                0:       bus.rready = 1'b1;
                1:       bus.rready = 1'($urandom_range(0, 1));
                default: bus.rready = 1'b0;
            endcase
        end
    end

    initial begin
        bus.bready = 1'b0;
        forever begin
            @(posedge aclk); #1;
            case (bready_mode)
                0:       bus.bready = 1'b1;
                1:       bus.bready = 1'($urandom_range(0, 1));
                default: bus.bready = 1'b0;
            endcase
        end
    end

    // ---------------- Monitors ----------------
    always @(negedge aclk) begin
        if (aresetn && bus.rvalid) begin
            if (r_exp.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL r_unexpected: got beat rdata=%h rid=%h, expected no beat", bus.rdata, bus.rid);
            end else begin
                check("rdata", bus.rdata, r_exp[0].data);
                check("rid", 32'(bus.rid), 32'(r_exp[0].id));
                check("rlast", 32'(bus.rlast), 32'(r_exp[0].last));
                check("rresp", 32'(bus.rresp), 32'd0);
                if (bus.rready) r_exp.delete(0);
            end
        end
    end

    always @(negedge aclk) begin
        if (aresetn && bus.bvalid) begin
            if (b_exp.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_unexpected: got response bid=%h, expected none", bus.bid);
            end else begin
                check("bid", 32'(bus.bid), 32'(b_exp[0]));
                check("bresp", 32'(bus.bresp), 32'd0);
                if (bus.bready) b_exp.delete(0);
            end
        end
    end

    // ---------------- Drivers (start and end at posedge+1) ----------------
    task automatic ar_send(input logic [3:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [2:0] size);
        r_beat_t     e;
        logic [31:0] a;
        int          n;
        for (int i = 0; i <= int'(len); i++) begin
            a      = addr + 32'(i) * step_of(size);
            e.id   = id;
            e.data = ref_mem[word_of(a)];
            e.last = (i == int'(len));
            r_exp.push_back(e);
        end
        bus.arid    = id;
        bus.araddr  = addr;
        bus.arlen   = len;
        bus.arsize  = size;
        bus.arburst = 2'($urandom);
        bus.arvalid = 1'b1;
        n = 0;
        do begin @(negedge aclk); n++; end while (!bus.arready && n < 200);
        check("ar_accept", 32'(bus.arready), 32'd1);
        @(posedge aclk); #1;
        bus.arvalid = 1'b0;
    endtask

    task automatic aw_send(input logic [3:0] id, input logic [31:0] addr,
                           input logic [3:0] len, input logic [2:0] size);
        int n;
        b_exp.push_back(id);
        bus.awid    = id;
        bus.awaddr  = addr;
        bus.awlen   = len;
        bus.awsize  = size;
        bus.awburst = 2'($urandom);
        bus.awvalid = 1'b1;
        n = 0;
        do begin @(negedge aclk); n++; end while (!bus.awready && n < 200);
        check("aw_accept", 32'(bus.awready), 32'd1);
        @(posedge aclk); #1;
        bus.awvalid = 1'b0;
    endtask

    task automatic w_beats(input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input bit gap);
        logic [31:0] a;
        int          w;
        int          n;
        for (int i = 0; i <= int'(len); i++) begin
            if (gap && i > 0) begin @(posedge aclk); #1; end
            a = addr + 32'(i) * step_of(size);
            w = word_of(a);
            for (int b = 0; b < 4; b++)
                if (ws_buf[i][b]) ref_mem[w][8*b +: 8] = wd_buf[i][8*b +: 8];
            bus.wdata  = wd_buf[i];
            bus.wstrb  = ws_buf[i];
            bus.wlast  = (i == int'(len));
            bus.wid    = 4'($urandom);
            bus.wvalid = 1'b1;
            n = 0;
            do begin @(negedge aclk); n++; end while (!bus.wready && n < 200);
            check("w_accept", 32'(bus.wready), 32'd1);
            @(posedge aclk); #1;
            bus.wvalid = 1'b0;
        end
    endtask

    task automatic axi_write(input logic [3:0] id, input logic [31:0] addr,
                             input logic [3:0] len, input logic [2:0] size, input bit gap);
        aw_send(id, addr, len, size);
        w_beats(addr, len, size, gap);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((r_exp.size() != 0 || b_exp.size() != 0) && n < 3000) begin
            @(posedge aclk);
            n++;
        end
        check("drain_r", 32'(r_exp.size()), 32'd0);
        check("drain_b", 32'(b_exp.size()), 32'd0);
        r_exp.delete();
        b_exp.delete();
        #1;
    endtask

    // ---------------- Stimulus ----------------
    initial begin
        logic [31:0] addr;
        logic [3:0]  wlen;
        logic [2:0]  wsz;
        int          n;

        bus.arvalid = 1'b0; bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0;
        bus.arburst = '0; bus.arlock = '0; bus.arcache = '0; bus.arprot = '0;
        bus.awvalid = 1'b0; bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0;
        bus.awburst = '0; bus.awlock = '0; bus.awcache = '0; bus.awprot = '0;
        bus.wvalid = 1'b0; bus.wid = '0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0;

        repeat (3) @(negedge aclk);
        check("rst_arready", 32'(bus.arready), 32'd0);
        check("rst_awready", 32'(bus.awready), 32'd0);
        check("rst_rvalid", 32'(bus.rvalid), 32'd0);
        check("rst_wready", 32'(bus.wready), 32'd0);
        check("rst_bvalid", 32'(bus.bvalid), 32'd0);
        check("rst_rdata", bus.rdata, 32'd0);
        aresetn = 1'b1;
        @(negedge aclk);
        check("post_rst_arready", 32'(bus.arready), 32'd1);
        check("post_rst_awready", 32'(bus.awready), 32'd1);
        @(posedge aclk); #1;

        // Give every word a known value so any later read has a defined expectation.
        for (int blk = 0; blk < DEPTH / 16; blk++) begin
            for (int i = 0; i < 16; i++) begin
                wd_buf[i] = $urandom;
                ws_buf[i] = 4'hF;
            end
            axi_write(4'(blk), 32'(blk * 64), 4'd15, 3'd2, 1'b0);
        end
        wait_idle();

        // Single read with exact latency checks.
        wd_buf[0] = 32'hDEADBEEF; ws_buf[0] = 4'hF;
        axi_write(4'h1, 32'h40, 4'd0, 3'd2, 1'b0);
        wait_idle();
        ar_send(4'h5, 32'h40, 8'd0, 3'd2);
        @(negedge aclk);
        check("rvalid_t1", 32'(bus.rvalid), 32'd0);
        @(negedge aclk);
        check("rvalid_t2", 32'(bus.rvalid), 32'd1);
        @(negedge aclk);
        check("arready_after_r", 32'(bus.arready), 32'd1);
        check("rvalid_dropped", 32'(bus.rvalid), 32'd0);
        @(posedge aclk); #1;
        wait_idle();

        // Byte-strobed merge with response held while bready is low.
        wd_buf[0] = 32'hAABBCCDD; ws_buf[0] = 4'hF;
        axi_write(4'h9, 32'h80, 4'd0, 3'd2, 1'b0);
        wait_idle();
        bready_mode = 2;
        wd_buf[0] = 32'h11223344; ws_buf[0] = 4'b0101;
        axi_write(4'hA, 32'h80, 4'd0, 3'd2, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            check("bvalid_hold", 32'(bus.bvalid), 32'd1);
        end
        bready_mode = 0;
        wait_idle();
        @(negedge aclk);
        check("awready_after_b", 32'(bus.awready), 32'd1);
        @(posedge aclk); #1;
        ar_send(4'hB, 32'h80, 8'd0, 3'd2);
        wait_idle();

        // Gapped write burst, then read back with a stalling master.
        for (int i = 0; i < 4; i++) begin wd_buf[i] = 32'(i + 1); ws_buf[i] = 4'hF; end
        axi_write(4'h1, 32'h100, 4'd3, 3'd2, 1'b1);
        wait_idle();
        rready_mode = 1;
        ar_send(4'h2, 32'h100, 8'd3, 3'd2);
        wait_idle();
        rready_mode = 0;

        // Byte-sized beats, 32-bit address wrap, aliasing and oversize arsize.
        ar_send(4'h4, 32'h3, 8'd1, 3'd0);
        wait_idle();
        ar_send(4'h6, 32'hFFFF_FFFC, 8'd1, 3'd2);
        wait_idle();
        wd_buf[0] = 32'h12345678; ws_buf[0] = 4'hF;
        axi_write(4'h3, 32'h408, 4'd0, 3'd2, 1'b0);
        wait_idle();
        ar_send(4'h7, 32'h8, 8'd0, 3'd2);
        wait_idle();
        ar_send(4'h8, 32'h20, 8'd2, 3'd3);
        wait_idle();

        // Fetch and write beat to the same word on the same edge.
        wd_buf[0] = 32'd5; ws_buf[0] = 4'hF;
        axi_write(4'h1, 32'h200, 4'd0, 3'd2, 1'b0);
        wait_idle();
        aw_send(4'h2, 32'h200, 4'd0, 3'd2);
        ar_send(4'h3, 32'h200, 8'd0, 3'd2);
        bus.wdata  = 32'd9;
        bus.wstrb  = 4'hF;
        bus.wlast  = 1'b1;
        bus.wvalid = 1'b1;
        ref_mem[word_of(32'h200)] = 32'd9;
        @(negedge aclk);
        check("w_same_cycle", 32'(bus.wready), 32'd1);
        @(posedge aclk); #1;
        bus.wvalid = 1'b0;
        wait_idle();
        ar_send(4'h4, 32'h200, 8'd0, 3'd2);
        wait_idle();

        // Randomized write-then-read traffic.
        for (int it = 0; it < 12; it++) begin
            addr = $urandom;
            wlen = 4'($urandom_range(0, 15));
            wsz  = 3'($urandom_range(0, 3));
            for (int i = 0; i < 16; i++) begin
                wd_buf[i] = $urandom;
                ws_buf[i] = 4'($urandom);
            end
            bready_mode = 1;
            axi_write(4'($urandom), addr, wlen, wsz, 1'($urandom_range(0, 1)));
            wait_idle();
            rready_mode = 1;
            ar_send(4'($urandom), addr, 8'($urandom_range(0, 31)), 3'($urandom_range(0, 3)));
            wait_idle();
        end
        rready_mode = 0;
        bready_mode = 0;

        // Reset in the middle of a 4-beat read, on beat 1.
        ar_send(4'hC, 32'h100, 8'd3, 3'd2);
        n = 0;
        do begin @(posedge aclk); #2; n++; end while (!(r_exp.size() == 3 && bus.rvalid) && n < 50);
        check("beat1_reached", 32'(r_exp.size()), 32'd3);
        aresetn = 1'b0;
        #1;
        check("midrst_rvalid", 32'(bus.rvalid), 32'd0);
        check("midrst_rlast", 32'(bus.rlast), 32'd0);
        check("midrst_rdata", bus.rdata, 32'd0);
        check("midrst_rid", 32'(bus.rid), 32'd0);
        check("midrst_arready", 32'(bus.arready), 32'd0);
        r_exp.delete();
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        check("rerst_arready", 32'(bus.arready), 32'd1);
        check("rerst_rvalid", 32'(bus.rvalid), 32'd0);
        @(posedge aclk); #1;
        for (int blk = 0; blk < DEPTH / 64; blk++) begin
            ar_send(4'(blk), 32'(blk * 256), 8'd63, 3'd2);
            wait_idle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at t=%0t, expected completion", $time);
        $fatal(1);
    end

endmodule
